// File: rtl/wbr_ctrl_pkg.sv
// Shared types for the wrapper boundary scan controller: instruction and FSM
// encodings plus the instruction-to-cell-configuration decode.
package wbr_ctrl_pkg;

    typedef enum logic [1:0] {
        BYPASS = 2'b00,
        INTEST = 2'b01,
        EXTEST = 2'b10,
        SAFE   = 2'b11
    } instr_e;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        SHIFT,
        TRANSFER,
        UPDATE,
        DONE
    } state_e;

    typedef struct packed {
        logic mode;
        logic io_face;
        logic safe;
    } cfg_t;

    function automatic cfg_t decode_cfg(input instr_e ins);
        cfg_t cfg;
        case (ins)
            INTEST:  cfg = '{mode: 1'b1, io_face: 1'b1, safe: 1'b0};
            EXTEST:  cfg = '{mode: 1'b1, io_face: 1'b0, safe: 1'b0};
            SAFE:    cfg = '{mode: 1'b1, io_face: 1'b0, safe: 1'b1};
            default: cfg = '{mode: 1'b0, io_face: 1'b0, safe: 1'b0};
        endcase
        return cfg;
    endfunction

    // Only INTEST and EXTEST walk the chain; BYPASS and SAFE just reconfigure.
    function automatic logic is_scan(input instr_e ins);
        return (ins == INTEST) || (ins == EXTEST);
    endfunction

endpackage

// File: rtl/wbr_scan_shreg.sv
// Paired shift registers: a PISO that feeds the chain input bit 0 first and a
// SIPO that gathers the chain output so the first bit lands in par_out[0].
module wbr_scan_shreg #(
    parameter int CHAIN_LEN = 16
) (
    input  logic                 wrck,
    input  logic                 arst,
    input  logic                 load,
    input  logic                 shift_en,
    input  logic [CHAIN_LEN-1:0] par_in,
    input  logic                 si,
    output logic                 so,
    output logic [CHAIN_LEN-1:0] par_out
);

    logic [CHAIN_LEN-1:0] pat_q;
    logic [CHAIN_LEN-1:0] resp_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge wrck or posedge arst) begin
        if (arst) begin
            pat_q  <= '0;
            resp_q <= '0;
        end else if (load) begin
            pat_q  <= par_in;
            resp_q <= '0;
        end else if (shift_en) begin
            pat_q  <= pat_q >> 1;
            resp_q <= {si, resp_q[CHAIN_LEN-1:1]};
        end
    end

    assign so      = pat_q[0];
    assign par_out = resp_q;

endmodule

// File: rtl/wbr_scan_ctrl.sv
// Wrapper boundary scan sequencer: latches an instruction on start and runs
// capture / shift / transfer / update over a chain of CHAIN_LEN cells.
module wbr_scan_ctrl
    import wbr_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 16
) (
    input  logic                 wrck,
    input  logic                 arst,
    input  logic                 start,
    input  logic [1:0]           instr,
    input  logic [CHAIN_LEN-1:0] pat_in,
    input  logic                 wso,
    output logic                 wsi,
    output logic                 shift,
    output logic                 capture,
    output logic                 transfer,
    output logic                 update,
    output logic                 mode,
    output logic                 io_face,
    output logic                 safe,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] resp
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);

    state_e           state_q;
    state_e           state_d;
    instr_e           ir_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             shift_last;
    logic             pat_bit;
    cfg_t             cfg;

    assign accept     = (state_q == IDLE) && start;
    assign shift_last = (cnt_q == CNT_W'(CHAIN_LEN - 1));

    always_ff @(posedge wrck or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            ir_q    <= BYPASS;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ir_q  <= instr_e'(instr);
                cnt_q <= '0;
            end else if (state_q == SHIFT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a latch behind.
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        shift    = 1'b0;
        transfer = 1'b0;
        update   = 1'b0;
        done     = 1'b0;
        wsi      = 1'b0;
        busy     = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start) state_d = is_scan(instr_e'(instr)) ? CAPTURE : DONE;
            end
            CAPTURE: begin
                capture = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                shift = 1'b1;
                wsi   = pat_bit;
                if (shift_last) state_d = TRANSFER;
            end
            TRANSFER: begin
                transfer = 1'b1;
                state_d  = UPDATE;
            end
            UPDATE: begin
                update  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Configuration follows the latched instruction, never the live input.
    assign cfg     = decode_cfg(ir_q);
    assign mode    = cfg.mode;
    assign io_face = cfg.io_face;
    assign safe    = cfg.safe;

    wbr_scan_shreg #(
        .CHAIN_LEN(CHAIN_LEN)
    ) u_shreg (
        .wrck     (wrck),
        .arst     (arst),
        .load     (accept),
        .shift_en (state_q == SHIFT),
        .par_in   (pat_in),
        .si       (wso),
        .so       (pat_bit),
        .par_out  (resp)
    );

endmodule

// File: tb/tb_wbr_scan_ctrl.sv
// Self-checking bench for wbr_scan_ctrl: a 16-cell and a 2-cell instance, each
// looped through a behavioural chain, checked cycle by cycle against a timeline model.
module tb_wbr_scan_ctrl;

    localparam int NA = 16;
    localparam int NB = 2;

    logic wrck;
    logic arst;

    logic          start_a, wso_a, wsi_a, shift_a, capture_a, transfer_a, update_a;
    logic          mode_a, io_face_a, safe_a, busy_a, done_a;
    logic [1:0]    instr_a;
    logic [NA-1:0] pat_a, resp_a, chain_a;

    logic          start_b, wso_b, wsi_b, shift_b, capture_b, transfer_b, update_b;
    logic          mode_b, io_face_b, safe_b, busy_b, done_b;
    logic [1:0]    instr_b;
    logic [NB-1:0] pat_b, resp_b, chain_b;

    int n_checks;
    int n_errors;

    // Which instance the stimulus and observation helpers are currently aimed at.
    logic        sel;
    logic        o_wsi, o_shift, o_capture, o_transfer, o_update;
    logic        o_mode, o_io_face, o_safe, o_busy, o_done;
    logic [15:0] o_resp, o_chain;

    // Expected {mode, io_face, safe} per instruction code.
    logic [2:0] cfg_tab [4];

    initial wrck = 1'b0;
    always #5 wrck = ~wrck;

    assign wso_a = chain_a[0];
    assign wso_b = chain_b[0];

    wbr_scan_ctrl #(.CHAIN_LEN(NA)) dut_a (
        .wrck(wrck), .arst(arst), .start(start_a), .instr(instr_a), .pat_in(pat_a),
        .wso(wso_a), .wsi(wsi_a), .shift(shift_a), .capture(capture_a),
        .transfer(transfer_a), .update(update_a), .mode(mode_a), .io_face(io_face_a),
        .safe(safe_a), .busy(busy_a), .done(done_a), .resp(resp_a)
    );

    wbr_scan_ctrl #(.CHAIN_LEN(NB)) dut_b (
        .wrck(wrck), .arst(arst), .start(start_b), .instr(instr_b), .pat_in(pat_b),
        .wso(wso_b), .wsi(wsi_b), .shift(shift_b), .capture(capture_b),
        .transfer(transfer_b), .update(update_b), .mode(mode_b), .io_face(io_face_b),
        .safe(safe_b), .busy(busy_b), .done(done_b), .resp(resp_b)
    );

    always_comb begin
        if (sel) begin
            {o_wsi, o_shift, o_capture, o_transfer, o_update} =
                {wsi_b, shift_b, capture_b, transfer_b, update_b};
            {o_mode, o_io_face, o_safe, o_busy, o_done} =
                {mode_b, io_face_b, safe_b, busy_b, done_b};
            o_resp  = {{(16-NB){1'b0}}, resp_b};
            o_chain = {{(16-NB){1'b0}}, chain_b};
        end else begin
            {o_wsi, o_shift, o_capture, o_transfer, o_update} =
                {wsi_a, shift_a, capture_a, transfer_a, update_a};
            {o_mode, o_io_face, o_safe, o_busy, o_done} =
                {mode_a, io_face_a, safe_a, busy_a, done_a};
            o_resp  = resp_a;
            o_chain = chain_a;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [1:0] ins, input logic [15:0] p);
        if (sel) begin
            start_b = s; instr_b = ins; pat_b = p[NB-1:0];
        end else begin
            start_a = s; instr_a = ins; pat_a = p;
        end
    endtask

    task automatic chain_load(input logic [15:0] v);
        if (sel) chain_b = v[NB-1:0];
        else     chain_a = v;
    endtask

    // One cell-to-cell move of the behavioural chain: wsi enters the top, wso leaves bit 0.
    task automatic chain_shift(input logic b);
        if (sel) chain_b = {b, chain_b[NB-1:1]};
        else     chain_a = {b, chain_a[NA-1:1]};
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {o_capture, o_shift, o_transfer, o_update, o_done, o_busy, o_wsi}, 7'd0);
        check({tag, "_cfg"}, {o_mode, o_io_face, o_safe}, 3'd0);
        check({tag, "_resp"}, o_resp, 16'h0);
    endtask

    // Runs one command on the selected instance and checks every cycle from 1
    // through the first cycle after done. With hold, start stays high and the
    // instruction is kept, so the following edge re-accepts.
    task automatic run_seq(input logic s, input logic [1:0] ins, input logic [15:0] pat,
                           input logic [15:0] pre, input bit hold);
        int          n;
        int          last;
        bit          scan;
        bit          pend;
        logic        pend_bit;
        logic [15:0] mask;
        logic [15:0] exp_resp;
        logic [15:0] exp_chain;
        logic        e_cap, e_sh, e_tr, e_up, e_dn, e_busy, e_wsi;

        sel       = s;
        n         = s ? NB : NA;
        mask      = 16'((1 << n) - 1);
        scan      = (ins == 2'b01) || (ins == 2'b10);
        last      = scan ? n + 4 : 1;
        exp_resp  = scan ? (pre & mask) : 16'h0;
        exp_chain = scan ? (pat & mask) : (pre & mask);
        pend      = 1'b0;
        pend_bit  = 1'b0;

        @(negedge wrck);
        chain_load(pre & mask);
        drive(1'b1, ins, pat);

        for (int c = 1; c <= last + 1; c++) begin
            @(negedge wrck);
            if (c == 1) begin
                if (hold) drive(1'b1, ins, pat);
                else      drive(1'b0, 2'($urandom), 16'($urandom));
            end
            if (pend) chain_shift(pend_bit);
            pend = 1'b0;

            e_cap  = scan && (c == 1);
            e_sh   = scan && (c >= 2) && (c <= n + 1);
            e_tr   = scan && (c == n + 2);
            e_up   = scan && (c == n + 3);
            e_dn   = (c == last);
            e_busy = (c <= last);
            e_wsi  = e_sh ? pat[c-2] : 1'b0;

            check("strobes", {o_capture, o_shift, o_transfer, o_update, o_done, o_busy},
                  {e_cap, e_sh, e_tr, e_up, e_dn, e_busy});
            check("wsi", o_wsi, e_wsi);
            check("exclusive", ($countones({o_capture, o_shift, o_transfer, o_update}) <= 1), 1'b1);
            check("cfg", {o_mode, o_io_face, o_safe}, cfg_tab[ins]);
            if (c == last) begin
                check("resp_at_done", o_resp, exp_resp);
                check("chain_loaded", o_chain & mask, exp_chain);
            end
            if (c == last + 1) check("resp_hold", o_resp, exp_resp);

            if (o_shift) begin
                pend     = 1'b1;
                pend_bit = o_wsi;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1);
    end

    initial begin
        cfg_tab[0] = 3'b000;
        cfg_tab[1] = 3'b110;
        cfg_tab[2] = 3'b100;
        cfg_tab[3] = 3'b101;
        n_checks = 0;
        n_errors = 0;
        sel      = 1'b0;
        arst     = 1'b1;
        start_a  = 1'b0; instr_a = 2'b00; pat_a = '0; chain_a = '0;
        start_b  = 1'b0; instr_b = 2'b00; pat_b = '0; chain_b = '0;

        #1;
        check_reset_outputs("reset_a");
        repeat (2) @(negedge wrck);
        sel = 1'b1;
        #1;
        check_reset_outputs("reset_b");
        sel  = 1'b0;
        arst = 1'b0;

        // Directed cases.
        run_seq(1'b0, 2'b10, 16'hA5C3, 16'($urandom), 1'b0);
        run_seq(1'b0, 2'b01, 16'($urandom), 16'h1234, 1'b0);
        run_seq(1'b0, 2'b00, 16'hFFFF, 16'($urandom), 1'b0);
        run_seq(1'b0, 2'b11, 16'($urandom), 16'($urandom), 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge wrck);
            check("safe_held", {o_mode, o_io_face, o_safe, o_busy, o_done, o_shift}, 6'b101000);
        end
        run_seq(1'b1, 2'b01, 16'h0002, 16'h0001, 1'b0);
        run_seq(1'b1, 2'b10, 16'h0001, 16'h0003, 1'b0);

        // Randomized commands across both instances.
        for (int i = 0; i < 24; i++) begin
            run_seq(logic'(i % 4 == 3), 2'($urandom), 16'($urandom), 16'($urandom), 1'b0);
        end

        // start held through an EXTEST run: one sequence, re-accepted only from IDLE.
        run_seq(1'b0, 2'b10, 16'($urandom), 16'($urandom), 1'b1);
        @(negedge wrck);
        check("hold_restart", {o_capture, o_busy}, 2'b11);
        drive(1'b0, 2'b00, 16'h0);
        repeat (4) @(negedge wrck);
        check("mid_shift", o_shift, 1'b1);

        // Asynchronous reset in the middle of the shift.
        #2 arst = 1'b1;
        #1;
        check_reset_outputs("arst_mid");
        repeat (2) begin
            @(negedge wrck);
            check("arst_no_done", {o_done, o_busy}, 2'b00);
        end
        arst = 1'b0;
        run_seq(1'b0, 2'b01, 16'($urandom), 16'($urandom), 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
